i2c_bit_sched: RTL and testbench

Bit-level timing scheduler for the I2C master. It divides `clk_in` into programmable quarter-bit periods and runs one bus primitive per command: START, STOP, WRITE bit or READ bit. Each primitive drives open-drain SCL/SDA enables through four fixed phases. It sits between the byte-level I2C controller and the pad enables, and replaces free-running divided clocks with a command-sequenced SCL that honours slave clock stretching.

---
 rtl/i2c_bit_sched.sv | 147 ++++++++++++++
 tb/tb_i2c_bit_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_sched.sv
// rtl/i2c_bit_sched.sv - command-sequenced I2C bit scheduler (START/STOP/WRITE/READ)
// Each command runs four quarter-bit phases; SCL high phase (PB) honours slave clock stretching.
module i2c_bit_sched #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 25
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             cmd_din,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             rsp_valid,
  output logic             rsp_dout,
  output logic             busy,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oen,
  output logic             sda_oen
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic [2:0] {IDLE, PA, PB, PC, PD} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt_q, cnt_nx, div_q, div_nx;
  logic [1:0]       cmd_q, cmd_nx;
  logic             din_q, din_nx;
  logic             scl_q, sda_q;
  logic [1:0]       en_nx;
  logic             samp_q, samp_nx;
  logic             rsp_valid_q, rsp_valid_nx;
  logic             rsp_dout_q, rsp_dout_nx;
  logic             hold;

  // {scl_oen, sda_oen} for a given phase of a given command
  function automatic logic [1:0] phase_en(input state_t s, input logic [1:0] c, input logic d);
    logic [1:0] en;
    en = 2'b11;
    case (c)
      CMD_START: case (s)
        PC:      en = 2'b10;
        PD:      en = 2'b00;
        default: en = 2'b11;
      endcase
      CMD_STOP: case (s)
        PA:      en = 2'b00;
        PB, PC:  en = 2'b10;
        default: en = 2'b11;
      endcase
      default: en = {(s == PB) || (s == PC), (c == CMD_WRITE) ? d : 1'b1};
    endcase
    return en;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign scl_oen   = scl_q;
  assign sda_oen   = sda_q;
  assign hold      = (state == PB) && !scl_i;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt_q;
    div_nx       = div_q;
    cmd_nx       = cmd_q;
    din_nx       = din_q;
    en_nx        = {scl_q, sda_q};
    samp_nx      = samp_q;
    rsp_valid_nx = 1'b0;
    rsp_dout_nx  = rsp_dout_q;
    if (state == IDLE) begin
      if (div_load)
        div_nx = (div_value < DIV_MIN) ? DIV_MIN : div_value;
      if (cmd_valid) begin
        cmd_nx   = cmd;
        din_nx   = cmd_din;
        cnt_nx   = '0;
        state_nx = PA;
        en_nx    = phase_en(PA, cmd, cmd_din);
      end
    end else if (hold) begin
      cnt_nx = '0;
    end else if (cnt_q == div_q - ONE) begin
      cnt_nx = '0;
      case (state)
        PA: begin
          state_nx = PB;
          en_nx    = phase_en(PB, cmd_q, din_q);
        end
        PB: begin
          state_nx = PC;
          en_nx    = phase_en(PC, cmd_q, din_q);
        end
        PC: begin
          state_nx = PD;
          en_nx    = phase_en(PD, cmd_q, din_q);
          samp_nx  = sda_i;
        end
        default: begin
          // enables keep their PD values while idle
          state_nx     = IDLE;
          rsp_valid_nx = 1'b1;
          rsp_dout_nx  = cmd_q[1] & samp_q;
        end
      endcase
    end else begin
      cnt_nx = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_W'(DIV_DEFAULT);
      cmd_q       <= CMD_START;
      din_q       <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      samp_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt_q       <= cnt_nx;
      div_q       <= div_nx;
      cmd_q       <= cmd_nx;
      din_q       <= din_nx;
      scl_q       <= en_nx[1];
      sda_q       <= en_nx[0];
      samp_q      <= samp_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_dout_q  <= rsp_dout_nx;
    end
  end

endmodule

// File: tb/tb_i2c_bit_sched.sv
// tb/tb_i2c_bit_sched.sv - table-driven bench for i2c_bit_sched
module tb_i2c_bit_sched;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_din = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = 16'd0;
  logic        rsp_valid, rsp_dout, busy;
  logic        scl_i, sda_i, scl_oen, sda_oen;
  logic        stretch = 1'b0;
  logic        pull = 1'b0;

  int nchk = 0;
  int nerr = 0;

  // open-drain bus: a slave may hold SCL low (stretch) or pull SDA low
  assign scl_i = scl_oen & ~stretch;
  assign sda_i = sda_oen & ~pull;

  i2c_bit_sched #(.DIV_W(16), .DIV_DEFAULT(25)) dut (
    .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_din(cmd_din), .div_load(div_load), .div_value(div_value),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oen(scl_oen), .sda_oen(sda_oen)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        ld;
    logic [15:0] dv;
    logic [1:0]  c;
    logic        d;
    logic        b2b;
    int          st_from;
    int          st_to;
    int          pull_from;
    int          mid_ld;
    int          e_scl_rise;
    int          e_scl_fall;
    int          e_sda_rise;
    int          e_sda_fall;
    int          e_done;
    logic        e_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   guard, t_sr, t_sf, t_dr, t_df, t_done;
    logic rdy, rv_at, ps, pd, dout;
    cmd_valid = 1'b1;
    cmd       = v.c;
    cmd_din   = v.d;
    div_load  = v.ld;
    div_value = v.dv;
    guard = 0; rdy = 1'b0; rv_at = 1'b0; ps = 1'b1; pd = 1'b1; dout = 1'b0;
    while (!rdy && guard < 500) begin
      rdy   = cmd_ready;
      rv_at = rsp_valid;
      ps    = scl_oen;
      pd    = sda_oen;
      @(posedge clk_in); #1;
      guard++;
    end
    chk({nm, " accept"}, {31'd0, rdy}, 32'd1);
    if (v.b2b) chk({nm, " accept_during_rsp"}, {31'd0, rv_at}, 32'd1);
    cmd_valid = 1'b0;
    div_load  = 1'b0;
    t_sr = -1; t_sf = -1; t_dr = -1; t_df = -1; t_done = -1;
    for (int n = 0; n < 500; n++) begin
      if (scl_oen !== ps) begin
        if (scl_oen && t_sr < 0) t_sr = n;
        if (!scl_oen && t_sf < 0) t_sf = n;
        ps = scl_oen;
      end
      if (sda_oen !== pd) begin
        if (sda_oen && t_dr < 0) t_dr = n;
        if (!sda_oen && t_df < 0) t_df = n;
        pd = sda_oen;
      end
      if (rsp_valid) begin
        t_done = n;
        dout   = rsp_dout;
        break;
      end
      stretch = (n >= v.st_from) && (n <= v.st_to);
      pull    = (v.pull_from >= 0) && (n >= v.pull_from);
      if (n == v.mid_ld) begin
        div_load  = 1'b1;
        div_value = 16'd9;
      end else begin
        div_load = 1'b0;
      end
      @(posedge clk_in); #1;
    end
    stretch  = 1'b0;
    pull     = 1'b0;
    div_load = 1'b0;
    chk({nm, " scl_rise"}, t_sr, v.e_scl_rise);
    chk({nm, " scl_fall"}, t_sf, v.e_scl_fall);
    chk({nm, " sda_rise"}, t_dr, v.e_sda_rise);
    chk({nm, " sda_fall"}, t_df, v.e_sda_fall);
    chk({nm, " done_cycle"}, t_done, v.e_done);
    chk({nm, " rsp_dout"}, {31'd0, dout}, {31'd0, v.e_dout});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    vec_t vr;
    //          ld    dv     cmd   din   b2b  stf  stt  pull mid  sclR sclF sdaR sdaF done dout
    vecs[0] = '{1'b1, 16'd5, 2'b00, 1'b0, 1'b0, -1, -1, -1, -1,  -1,  15,  -1,  10,  20, 1'b0};
    vecs[1] = '{1'b0, 16'd0, 2'b10, 1'b0, 1'b1, -1, -1, -1, -1,   5,  15,  -1,  -1,  20, 1'b0};
    vecs[2] = '{1'b0, 16'd0, 2'b11, 1'b0, 1'b1, -1, -1, -1, -1,   5,  15,   0,  -1,  20, 1'b1};
    vecs[3] = '{1'b0, 16'd0, 2'b11, 1'b0, 1'b1,  5, 11, 18, -1,   5,  22,  -1,  -1,  27, 1'b0};
    vecs[4] = '{1'b1, 16'd0, 2'b01, 1'b0, 1'b1, -1, -1, -1, -1,   2,  -1,   6,   0,   8, 1'b0};
    vecs[5] = '{1'b0, 16'd0, 2'b00, 1'b0, 1'b1, -1, -1, -1,  3,  -1,   6,  -1,   4,   8, 1'b0};
    vecs[6] = '{1'b0, 16'd0, 2'b01, 1'b0, 1'b1, -1, -1, -1, -1,   2,  -1,   6,  -1,   8, 1'b0};
    vecs[7] = '{1'b1, 16'd3, 2'b10, 1'b1, 1'b1, -1, -1,  4, -1,   3,   0,  -1,  -1,  12, 1'b0};

    // asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("reset scl_oen", {31'd0, scl_oen}, 32'd1);
    chk("reset sda_oen", {31'd0, sda_oen}, 32'd1);
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_dout", {31'd0, rsp_dout}, 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst = 1'b0;
    @(posedge clk_in); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in PC of a WRITE 0 (div is 3 here, PC spans cycles 6..8)
    cmd_valid = 1'b1; cmd = 2'b10; cmd_din = 1'b0;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk_in);
    #1;
    chk("midrst pre scl_oen", {31'd0, scl_oen}, 32'd1);
    chk("midrst pre sda_oen", {31'd0, sda_oen}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("midrst scl_oen", {31'd0, scl_oen}, 32'd1);
    chk("midrst sda_oen", {31'd0, sda_oen}, 32'd1);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk_in); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (rsp_valid) seen++;
    end
    chk("midrst no rsp", seen, 0);
    vr = '{1'b0, 16'd0, 2'b00, 1'b0, 1'b0, -1, -1, -1, -1, -1, 75, -1, 50, 100, 1'b0};
    run_vec(vr, "start_default_div");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
